// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg: shared types and constants for the data BRAM arbiter.
// Holds the FSM state encoding, requester identities and the read tag format
// carried through the read latency pipeline.
package data_mem_arbiter_pkg;

  // Arbiter FSM states. The enum is used for debug visibility. The localparams
  // below are the encodings the FSM register actually uses.
  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Requester identity, used for the round-robin pointer and read routing.
  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_HOST = 1'b1
  } arb_owner_t;

  // Cycles from a read grant to valid data on the RAM douta port.
  localparam int DATA_MEM_READ_LATENCY = 2;

  // One slot of the read tag pipeline: is there a read in flight, and who owns it.
  typedef struct packed {
    logic       valid;
    arb_owner_t owner;
  } read_tag_t;

  // The requester that did not win. Used to flip the round-robin pointer.
  function automatic arb_owner_t other_owner(input arb_owner_t owner);
    return (owner == OWNER_CORE) ? OWNER_HOST : OWNER_CORE;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if: bundles the core port, host port and RAM port signals
// of the data BRAM arbiter.
// slave  : the arbiter side.
// master : the surrounding logic (core memory stage, host loader, RAM).
//
// Handshake: a request transfers in the cycle where *_valid_in && *_ready_out
// are both high. ready is combinational from valid, FSM state and pointer. A
// requester keeps addr/wdata/we stable from raising valid until it sees
// ready. At most one ready is high in any cycle. Read data returns later on
// *_rdata_out, qualified by a one-cycle *_rvalid_out pulse.
interface data_mem_arbiter_if
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);

  // core load/store port
  logic                  core_valid_in;
  logic                  core_ready_out;
  logic                  core_we_in;
  logic [ADDR_WIDTH-1:0] core_addr_in;
  logic [DATA_WIDTH-1:0] core_wdata_in;
  logic [DATA_WIDTH-1:0] core_rdata_out;
  logic                  core_rvalid_out;

  // host loader/debug port
  logic                  host_valid_in;
  logic                  host_ready_out;
  logic                  host_we_in;
  logic                  host_lock_in;
  logic [ADDR_WIDTH-1:0] host_addr_in;
  logic [DATA_WIDTH-1:0] host_wdata_in;
  logic [DATA_WIDTH-1:0] host_rdata_out;
  logic                  host_rvalid_out;

  // RAM port A
  logic [ADDR_WIDTH-1:0] ram_addr_out;
  logic [DATA_WIDTH-1:0] ram_din_out;
  logic                  ram_we_out;
  logic [DATA_WIDTH-1:0] ram_dout_in;

  // FSM observation
  arb_state_t            dbg_state;
  arb_owner_t            dbg_ptr;

  modport slave (
    input  core_valid_in, core_we_in, core_addr_in, core_wdata_in,
    output core_ready_out, core_rdata_out, core_rvalid_out,
    input  host_valid_in, host_we_in, host_lock_in, host_addr_in, host_wdata_in,
    output host_ready_out, host_rdata_out, host_rvalid_out,
    output ram_addr_out, ram_din_out, ram_we_out,
    input  ram_dout_in,
    output dbg_state, dbg_ptr
  );

  modport master (
    output core_valid_in, core_we_in, core_addr_in, core_wdata_in,
    input  core_ready_out, core_rdata_out, core_rvalid_out,
    output host_valid_in, host_we_in, host_lock_in, host_addr_in, host_wdata_in,
    input  host_ready_out, host_rdata_out, host_rvalid_out,
    input  ram_addr_out, ram_din_out, ram_we_out,
    output ram_dout_in,
    input  dbg_state, dbg_ptr
  );

endinterface

// File: rtl/data_mem_arbiter_read_tag_pipe.sv
// read_tag_pipe: shift register of {valid, owner} tags, DEPTH stages deep.
// The tail lines up with the cycle in which the RAM presents the data for
// the read that entered at the head. Asynchronous active-low clear drops
// every in-flight read.
module read_tag_pipe
  import data_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = DATA_MEM_READ_LATENCY
) (
  input  logic      clk_100mhz,
  input  logic      rst_in,
  input  read_tag_t tag_in,
  output read_tag_t tag_out
);

  read_tag_t stage_q [DEPTH];

  // Shift every cycle. The head takes the tag of this cycle's grant.
  always_ff @(posedge clk_100mhz or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the single-port data BRAM between the core
// load/store port and the host loader/debug port.
// - One grant per cycle, round-robin when both ports request.
// - The host may lock the RAM for bursts.
// - Read data is routed back to whichever port issued the read.
// Optional build macro DATA_MEM_ARB_LOCK_TIMEOUT_EN: after LOCK_MAX consecutive
// locked cycles, a waiting core forces the arbiter back to ARB and gets the
// next grant.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = DATA_MEM_READ_LATENCY,
  parameter int LOCK_MAX     = 64
) (
  input  logic                clk_100mhz,
  input  logic                rst_in,
  data_mem_arbiter_if.slave   bus
);

  // Reject parameter sets the pipeline or lock counter cannot represent.
  if (READ_LATENCY < 1 || LOCK_MAX < 1) begin : g_bad_params
    $error("data_mem_arbiter: READ_LATENCY and LOCK_MAX must be at least 1");
  end

  logic [0:0]            state_q, state_d;
  arb_owner_t            ptr_q, ptr_d;
  logic                  core_gnt, host_gnt;
  logic                  lock_timeout;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic                  ram_we;

  read_tag_t             rd_tag_head, rd_tag_tail;
  logic                  rd_issue;
  arb_owner_t            rd_owner;

  logic [DATA_WIDTH-1:0] core_rdata_q, host_rdata_q;
  logic                  core_rvalid_q, host_rvalid_q;

  // Grant selection. Reset suppresses every grant so the RAM is never written.
  always_comb begin
    core_gnt = 1'b0;
    host_gnt = 1'b0;
    if (rst_in) begin
      if (state_q == ST_LOCKED) begin
        host_gnt = bus.host_valid_in;
      end else if (bus.core_valid_in && bus.host_valid_in) begin
        core_gnt = (ptr_q == OWNER_CORE);
        host_gnt = (ptr_q == OWNER_HOST);
      end else begin
        core_gnt = bus.core_valid_in;
        host_gnt = bus.host_valid_in;
      end
    end
  end

  // FSM next state and round-robin pointer update.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_LOCKED) begin
      // Leaving the lock always hands the next conflict to the core.
      if (!bus.host_lock_in || lock_timeout) begin
        state_d = ST_ARB;
        ptr_d   = OWNER_CORE;
      end
    end else begin
      // Only contested cycles move the pointer. Lone requests leave it alone.
      if (bus.core_valid_in && bus.host_valid_in) begin
        ptr_d = other_owner(ptr_q);
      end
      if (host_gnt && bus.host_lock_in) begin
        state_d = ST_LOCKED;
      end
    end
  end

  // FSM state and pointer registers.
  always_ff @(posedge clk_100mhz or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_ARB;
      ptr_q   <= OWNER_CORE;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef DATA_MEM_ARB_LOCK_TIMEOUT_EN
  localparam int               CNT_W     = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX - 1);

  logic [CNT_W-1:0] lock_cnt_q;

  // Count consecutive LOCKED cycles. Any ARB cycle parks the count at zero,
  // so each new entry into LOCKED starts fresh.
  always_ff @(posedge clk_100mhz or negedge rst_in) begin
    if (!rst_in) begin
      lock_cnt_q <= '0;
    end else if (state_q != ST_LOCKED) begin
      lock_cnt_q <= '0;
    end else if (lock_cnt_q != LOCK_LAST) begin
      lock_cnt_q <= lock_cnt_q + 1'b1;
    end
  end

  // Fires in the LOCK_MAX-th locked cycle. It holds there until the core asks.
  assign lock_timeout = (state_q == ST_LOCKED) && (lock_cnt_q == LOCK_LAST)
                        && bus.core_valid_in;
`else
  // Without the timeout, LOCKED lasts for as long as the host holds its lock.
  assign lock_timeout = 1'b0;
`endif

  // RAM drive. With no grant, present the core address and never write.
  always_comb begin
    ram_addr = bus.core_addr_in;
    ram_din  = bus.core_wdata_in;
    ram_we   = core_gnt && bus.core_we_in;
    if (host_gnt) begin
      ram_addr = bus.host_addr_in;
      ram_din  = bus.host_wdata_in;
      ram_we   = bus.host_we_in;
    end
  end

  assign rd_issue    = (core_gnt && !bus.core_we_in) || (host_gnt && !bus.host_we_in);
  assign rd_owner    = host_gnt ? OWNER_HOST : OWNER_CORE;
  assign rd_tag_head = '{valid: rd_issue, owner: rd_owner};

  read_tag_pipe #(
    .DEPTH (READ_LATENCY)
  ) u_read_tag_pipe (
    .clk_100mhz (clk_100mhz),
    .rst_in     (rst_in),
    .tag_in     (rd_tag_head),
    .tag_out    (rd_tag_tail)
  );

  // Capture RAM data for the tail owner. The other port's rdata is untouched.
  always_ff @(posedge clk_100mhz or negedge rst_in) begin
    if (!rst_in) begin
      core_rdata_q  <= '0;
      host_rdata_q  <= '0;
      core_rvalid_q <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      core_rvalid_q <= rd_tag_tail.valid && (rd_tag_tail.owner == OWNER_CORE);
      host_rvalid_q <= rd_tag_tail.valid && (rd_tag_tail.owner == OWNER_HOST);
      if (rd_tag_tail.valid && (rd_tag_tail.owner == OWNER_CORE)) begin
        core_rdata_q <= bus.ram_dout_in;
      end
      if (rd_tag_tail.valid && (rd_tag_tail.owner == OWNER_HOST)) begin
        host_rdata_q <= bus.ram_dout_in;
      end
    end
  end

  assign bus.core_ready_out  = core_gnt;
  assign bus.host_ready_out  = host_gnt;
  assign bus.ram_addr_out    = ram_addr;
  assign bus.ram_din_out     = ram_din;
  assign bus.ram_we_out      = ram_we;
  assign bus.core_rdata_out  = core_rdata_q;
  assign bus.core_rvalid_out = core_rvalid_q;
  assign bus.host_rdata_out  = host_rdata_q;
  assign bus.host_rvalid_out = host_rvalid_q;
  assign bus.dbg_state       = arb_state_t'(state_q);
  assign bus.dbg_ptr         = ptr_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed bench for data_mem_arbiter, with a
// behavioural read-first BRAM that has a 2-cycle read latency.
// Build with DATA_MEM_ARB_LOCK_TIMEOUT_EN defined to cover the lock timeout
// scenario (LOCK_MAX = 4). The default build covers the unbounded lock.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  logic clk_100mhz;
  logic rst_n;
  int   checks;
  int   passes;

  data_mem_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  data_mem_arbiter #(
    .ADDR_WIDTH   (12),
    .DATA_WIDTH   (32),
    .READ_LATENCY (2),
    .LOCK_MAX     (4)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst_in     (rst_n),
    .bus        (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk_100mhz = 1'b0;
  always #5 clk_100mhz = ~clk_100mhz;

  // ---------------- BRAM model: read-first, 2-cycle read ----------------
  logic [31:0] ram_mem [4096];
  logic [31:0] ram_rd1;
  initial begin
    for (int i = 0; i < 4096; i++) ram_mem[i] = '0;
    ram_rd1 = '0;
    bus.ram_dout_in = '0;
  end
  always @(posedge clk_100mhz) begin
    ram_rd1 <= ram_mem[bus.ram_addr_out];
    bus.ram_dout_in <= ram_rd1;
    if (bus.ram_we_out) ram_mem[bus.ram_addr_out] <= bus.ram_din_out;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic idle_inputs();
    bus.core_valid_in = 1'b0;
    bus.core_we_in    = 1'b0;
    bus.core_addr_in  = '0;
    bus.core_wdata_in = '0;
    bus.host_valid_in = 1'b0;
    bus.host_we_in    = 1'b0;
    bus.host_lock_in  = 1'b0;
    bus.host_addr_in  = '0;
    bus.host_wdata_in = '0;
  endtask

  task automatic core_req(input logic we, input logic [11:0] addr, input logic [31:0] data);
    bus.core_valid_in = 1'b1;
    bus.core_we_in    = we;
    bus.core_addr_in  = addr;
    bus.core_wdata_in = data;
  endtask

  task automatic host_req(input logic we, input logic lock, input logic [11:0] addr,
                          input logic [31:0] data);
    bus.host_valid_in = 1'b1;
    bus.host_we_in    = we;
    bus.host_lock_in  = lock;
    bus.host_addr_in  = addr;
    bus.host_wdata_in = data;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    core_req(1'b1, 12'h00A, 32'h1234_5678);
    host_req(1'b1, 1'b0, 12'h00B, 32'h8765_4321);
    #1;
    checks++; if (bus.core_ready_out !== 1'b0) $display("FAIL reset_core_ready: got %0b want 0", bus.core_ready_out); else passes++;
    checks++; if (bus.host_ready_out !== 1'b0) $display("FAIL reset_host_ready: got %0b want 0", bus.host_ready_out); else passes++;
    checks++; if (bus.ram_we_out !== 1'b0) $display("FAIL reset_ram_we: got %0b want 0", bus.ram_we_out); else passes++;
    checks++; if (bus.core_rdata_out !== 32'h0) $display("FAIL reset_core_rdata: got %h want 0", bus.core_rdata_out); else passes++;
    checks++; if (bus.host_rdata_out !== 32'h0) $display("FAIL reset_host_rdata: got %h want 0", bus.host_rdata_out); else passes++;
    checks++; if (bus.core_rvalid_out !== 1'b0) $display("FAIL reset_core_rvalid: got %0b want 0", bus.core_rvalid_out); else passes++;
    checks++; if (bus.host_rvalid_out !== 1'b0) $display("FAIL reset_host_rvalid: got %0b want 0", bus.host_rvalid_out); else passes++;
    checks++; if (bus.dbg_state !== ARB) $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, ARB); else passes++;
    checks++; if (bus.dbg_ptr !== OWNER_CORE) $display("FAIL reset_ptr: got %0d want %0d", bus.dbg_ptr, OWNER_CORE); else passes++;
    step();
    idle_inputs();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_read();
    logic seen;
    core_req(1'b0, 12'h010, 32'h0);
    #1;
    checks++; if (bus.core_ready_out !== 1'b1) $display("FAIL midrd_grant: got %0b want 1", bus.core_ready_out); else passes++;
    step();
    // Assert reset while requests are still pending. Nothing may be granted.
    rst_n = 1'b0;
    core_req(1'b1, 12'h011, 32'hAAAA_5555);
    host_req(1'b1, 1'b0, 12'h012, 32'h5555_AAAA);
    #1;
    checks++; if (bus.core_ready_out !== 1'b0 || bus.host_ready_out !== 1'b0)
      $display("FAIL midrd_ready_in_reset: got core=%0b host=%0b want 0 0", bus.core_ready_out, bus.host_ready_out); else passes++;
    checks++; if (bus.ram_we_out !== 1'b0) $display("FAIL midrd_we_in_reset: got %0b want 0", bus.ram_we_out); else passes++;
    step();
    idle_inputs();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.core_rvalid_out || bus.host_rvalid_out) seen = 1'b1;
      step();
    end
    checks++; if (seen !== 1'b0) $display("FAIL midrd_dropped: got rvalid seen=%0b want 0", seen); else passes++;
    checks++; if (bus.core_rdata_out !== 32'h0) $display("FAIL midrd_rdata: got %h want 0", bus.core_rdata_out); else passes++;
  endtask

  task automatic test_write_read();
    core_req(1'b1, 12'h004, 32'hDEAD_BEEF);
    #1;
    checks++; if (bus.core_ready_out !== 1'b1) $display("FAIL wr_grant: got %0b want 1", bus.core_ready_out); else passes++;
    checks++; if (bus.ram_we_out !== 1'b1 || bus.ram_addr_out !== 12'h004 || bus.ram_din_out !== 32'hDEAD_BEEF)
      $display("FAIL wr_ram_drive: got we=%0b addr=%h din=%h want 1 004 deadbeef", bus.ram_we_out, bus.ram_addr_out, bus.ram_din_out); else passes++;
    step();
    core_req(1'b0, 12'h004, 32'h0);
    #1;
    checks++; if (bus.core_ready_out !== 1'b1 || bus.ram_we_out !== 1'b0)
      $display("FAIL rd_grant: got ready=%0b we=%0b want 1 0", bus.core_ready_out, bus.ram_we_out); else passes++;
    step();
    idle_inputs();
    checks++; if (bus.core_rvalid_out !== 1'b0) $display("FAIL rd_lat1: got %0b want 0", bus.core_rvalid_out); else passes++;
    step();
    checks++; if (bus.core_rvalid_out !== 1'b0) $display("FAIL rd_lat2: got %0b want 0", bus.core_rvalid_out); else passes++;
    step();
    checks++; if (bus.core_rvalid_out !== 1'b1 || bus.core_rdata_out !== 32'hDEAD_BEEF)
      $display("FAIL rd_lat3: got rvalid=%0b data=%h want 1 deadbeef", bus.core_rvalid_out, bus.core_rdata_out); else passes++;
    checks++; if (bus.host_rvalid_out !== 1'b0) $display("FAIL rd_host_quiet: got %0b want 0", bus.host_rvalid_out); else passes++;
    step();
    checks++; if (bus.core_rvalid_out !== 1'b0 || bus.core_rdata_out !== 32'hDEAD_BEEF)
      $display("FAIL rd_pulse_end: got rvalid=%0b data=%h want 0 deadbeef", bus.core_rvalid_out, bus.core_rdata_out); else passes++;
  endtask

  task automatic test_conflict();
    logic [3:0] exp_core_pattern;
    exp_core_pattern = 4'b0101;  // bit i: core wins cycle i (core, host, core, host)
    do_reset();
    core_req(1'b1, 12'h020, 32'hC0C0_0020);
    host_req(1'b1, 1'b0, 12'h030, 32'h4040_0030);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.core_ready_out !== exp_core_pattern[i] || bus.host_ready_out !== !exp_core_pattern[i])
        $display("FAIL conflict_cycle%0d: got core=%0b host=%0b want core=%0b host=%0b", i,
                 bus.core_ready_out, bus.host_ready_out, exp_core_pattern[i], !exp_core_pattern[i]); else passes++;
      checks++; if (bus.ram_addr_out !== (exp_core_pattern[i] ? 12'h020 : 12'h030))
        $display("FAIL conflict_addr%0d: got %h want %h", i, bus.ram_addr_out, exp_core_pattern[i] ? 12'h020 : 12'h030); else passes++;
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_interleaved();
    host_req(1'b1, 1'b0, 12'h001, 32'h1111_0001); step();
    host_req(1'b1, 1'b0, 12'h002, 32'h2222_0002); step();
    host_req(1'b1, 1'b0, 12'h003, 32'h3333_0003); step();
    idle_inputs();
    core_req(1'b0, 12'h001, 32'h0);
    #1;
    checks++; if (bus.core_ready_out !== 1'b1) $display("FAIL il_grant_core1: got %0b want 1", bus.core_ready_out); else passes++;
    step();
    idle_inputs();
    host_req(1'b0, 1'b0, 12'h002, 32'h0);
    #1;
    checks++; if (bus.host_ready_out !== 1'b1) $display("FAIL il_grant_host2: got %0b want 1", bus.host_ready_out); else passes++;
    step();
    idle_inputs();
    core_req(1'b0, 12'h003, 32'h0);
    #1;
    checks++; if (bus.core_ready_out !== 1'b1) $display("FAIL il_grant_core3: got %0b want 1", bus.core_ready_out); else passes++;
    step();
    idle_inputs();
    checks++; if (bus.core_rvalid_out !== 1'b1 || bus.host_rvalid_out !== 1'b0 || bus.core_rdata_out !== 32'h1111_0001)
      $display("FAIL il_resp1: got c=%0b h=%0b data=%h want 1 0 11110001", bus.core_rvalid_out, bus.host_rvalid_out, bus.core_rdata_out); else passes++;
    step();
    checks++; if (bus.host_rvalid_out !== 1'b1 || bus.core_rvalid_out !== 1'b0 || bus.host_rdata_out !== 32'h2222_0002)
      $display("FAIL il_resp2: got h=%0b c=%0b data=%h want 1 0 22220002", bus.host_rvalid_out, bus.core_rvalid_out, bus.host_rdata_out); else passes++;
    step();
    checks++; if (bus.core_rvalid_out !== 1'b1 || bus.host_rvalid_out !== 1'b0 || bus.core_rdata_out !== 32'h3333_0003)
      $display("FAIL il_resp3: got c=%0b h=%0b data=%h want 1 0 33330003", bus.core_rvalid_out, bus.host_rvalid_out, bus.core_rdata_out); else passes++;
    checks++; if (bus.host_rdata_out !== 32'h2222_0002) $display("FAIL il_host_hold: got %h want 22220002", bus.host_rdata_out); else passes++;
    step();
  endtask

`ifndef DATA_MEM_ARB_LOCK_TIMEOUT_EN
  task automatic test_host_lock();
    logic core_leak;
    do_reset();
    host_req(1'b1, 1'b1, 12'h100, 32'hA5A5_0100);
    #1;
    checks++; if (bus.host_ready_out !== 1'b1) $display("FAIL lock_enter: got %0b want 1", bus.host_ready_out); else passes++;
    step();
    checks++; if (bus.dbg_state !== LOCKED) $display("FAIL lock_state: got %0d want %0d", bus.dbg_state, LOCKED); else passes++;
    core_req(1'b0, 12'h004, 32'h0);
    core_leak = 1'b0;
    for (int i = 1; i < 8; i++) begin
      host_req(1'b1, 1'b1, 12'h100 + 12'(i), 32'hA5A5_0100 + 32'(i));
      #1;
      if (bus.core_ready_out !== 1'b0) core_leak = 1'b1;
      checks++; if (bus.host_ready_out !== 1'b1 || bus.ram_we_out !== 1'b1 || bus.ram_addr_out !== 12'h100 + 12'(i))
        $display("FAIL lock_burst%0d: got ready=%0b we=%0b addr=%h want 1 1 %h", i, bus.host_ready_out, bus.ram_we_out,
                 bus.ram_addr_out, 12'h100 + 12'(i)); else passes++;
      step();
    end
    // Idle but still locked: the core keeps waiting.
    bus.host_valid_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.core_ready_out !== 1'b0) core_leak = 1'b1;
      step();
    end
    checks++; if (core_leak !== 1'b0) $display("FAIL lock_core_blocked: got leak=%0b want 0", core_leak); else passes++;
    bus.host_lock_in = 1'b0;
    #1;
    checks++; if (bus.core_ready_out !== 1'b0) $display("FAIL lock_drop_cycle: got %0b want 0", bus.core_ready_out); else passes++;
    step();
    #1;
    checks++; if (bus.core_ready_out !== 1'b1 || bus.ram_addr_out !== 12'h004)
      $display("FAIL lock_release_grant: got ready=%0b addr=%h want 1 004", bus.core_ready_out, bus.ram_addr_out); else passes++;
    step();
    idle_inputs();
    step();
    step();
    checks++; if (bus.core_rvalid_out !== 1'b1 || bus.core_rdata_out !== 32'hDEAD_BEEF)
      $display("FAIL lock_core_resp: got rvalid=%0b data=%h want 1 deadbeef", bus.core_rvalid_out, bus.core_rdata_out); else passes++;
    host_req(1'b0, 1'b0, 12'h103, 32'h0);
    #1;
    checks++; if (bus.host_ready_out !== 1'b1) $display("FAIL lock_readback_grant: got %0b want 1", bus.host_ready_out); else passes++;
    step();
    idle_inputs();
    step();
    step();
    checks++; if (bus.host_rvalid_out !== 1'b1 || bus.host_rdata_out !== 32'hA5A5_0103)
      $display("FAIL lock_readback: got rvalid=%0b data=%h want 1 a5a50103", bus.host_rvalid_out, bus.host_rdata_out); else passes++;
    step();
  endtask
`else
  task automatic test_lock_timeout();
    logic core_leak;
    do_reset();
    host_req(1'b1, 1'b1, 12'h200, 32'h7700_0200);
    #1;
    checks++; if (bus.host_ready_out !== 1'b1) $display("FAIL to_enter: got %0b want 1", bus.host_ready_out); else passes++;
    step();
    core_req(1'b1, 12'h300, 32'h0C0C_0300);
    core_leak = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      host_req(1'b1, 1'b1, 12'h200 + 12'(i), 32'h7700_0200 + 32'(i));
      #1;
      if (bus.core_ready_out !== 1'b0) core_leak = 1'b1;
      checks++; if (bus.host_ready_out !== 1'b1) $display("FAIL to_locked%0d: got %0b want 1", i, bus.host_ready_out); else passes++;
      step();
    end
    checks++; if (core_leak !== 1'b0) $display("FAIL to_core_blocked: got leak=%0b want 0", core_leak); else passes++;
    #1;
    checks++; if (bus.core_ready_out !== 1'b1 || bus.host_ready_out !== 1'b0)
      $display("FAIL to_core_wins: got core=%0b host=%0b want 1 0", bus.core_ready_out, bus.host_ready_out); else passes++;
    step();
    core_req(1'b1, 12'h301, 32'h0C0C_0301);
    #1;
    checks++; if (bus.host_ready_out !== 1'b1 || bus.core_ready_out !== 1'b0)
      $display("FAIL to_relock: got host=%0b core=%0b want 1 0", bus.host_ready_out, bus.core_ready_out); else passes++;
    step();
    #1;
    checks++; if (bus.dbg_state !== LOCKED || bus.core_ready_out !== 1'b0)
      $display("FAIL to_relocked_state: got state=%0d core=%0b want %0d 0", bus.dbg_state, bus.core_ready_out, LOCKED); else passes++;
    idle_inputs();
    step();
    step();
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    passes = 0;
    idle_inputs();
    test_reset();
    test_reset_mid_read();
    test_write_read();
    test_conflict();
    test_interleaved();
`ifndef DATA_MEM_ARB_LOCK_TIMEOUT_EN
    test_host_lock();
`else
    test_lock_timeout();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
